// File: rtl/id_hazard_unit_pkg.sv
// rtl/id_hazard_unit_pkg.sv - shared GPR constants and forwarding channel indices for the ID hazard unit
package id_hazard_unit_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_NUM    = 32;

  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

  // Default channel order, youngest stage first (highest forwarding priority)
  typedef enum logic [1:0] {
    FWD_EXE = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_ch_e;

endpackage

// File: rtl/hazard_fwd_mux.sv
// rtl/hazard_fwd_mux.sv - per-source-port priority bypass search and hazard detection
module hazard_fwd_mux
  import id_hazard_unit_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32
) (
  input  logic                         src_en,
  input  gpr_addr_t                    src_addr,
  input  logic [DATA_W-1:0]            rf_rdata,
  input  logic [NUM_FWD-1:0]           fwd_valid,
  input  logic [NUM_FWD*GPR_ADDR_W-1:0] fwd_dest,
  input  logic [NUM_FWD-1:0]           fwd_data_ok,
  input  logic [NUM_FWD*DATA_W-1:0]    fwd_data,
  input  logic                         pend,
  output logic [DATA_W-1:0]            src_data,
  output logic                         hazard
);

  logic              hit;
  logic              hit_ok;
  logic [DATA_W-1:0] hit_data;

  // Scan oldest to youngest so the lowest matching channel overwrites and wins
  always_comb begin
    hit      = 1'b0;
    hit_ok   = 1'b0;
    hit_data = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_dest[i*GPR_ADDR_W +: GPR_ADDR_W] == src_addr)) begin
        hit      = 1'b1;
        hit_ok   = fwd_data_ok[i];
        hit_data = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // r0 reads as zero; an unready hit or a pending non-forwarding writer is a hazard
  always_comb begin
    src_data = rf_rdata;
    hazard   = 1'b0;
    if (src_addr == '0) begin
      src_data = '0;
    end else if (hit) begin
      if (hit_ok) begin
        src_data = hit_data;
      end else begin
        hazard = src_en;
      end
    end else if (pend) begin
      hazard = src_en;
    end
  end

endmodule

// File: rtl/id_hazard_unit.sv
// rtl/id_hazard_unit.sv - ID stage GPR scoreboard, bypass network and stall generation (optional ID_HAZ_STATS_EN)
module id_hazard_unit
  import id_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 3,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 3
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_SRC-1:0]            src_en,
  input  logic [NUM_SRC*GPR_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]     rf_rdata,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD*GPR_ADDR_W-1:0] fwd_dest,
  input  logic [NUM_FWD-1:0]            fwd_data_ok,
  input  logic [NUM_FWD*DATA_W-1:0]     fwd_data,
  input  logic                          cur_we,
  input  gpr_addr_t                     cur_dest,
  input  logic                          issue_fire,
  input  logic                          ret_valid,
  input  gpr_addr_t                     ret_dest,
  output logic [NUM_SRC*DATA_W-1:0]     src_data,
  output logic                          ds_stall,
  output logic                          sb_err
`ifdef ID_HAZ_STATS_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);

  logic [CNT_W-1:0] cnt_q [GPR_NUM];
  logic [CNT_W-1:0] cnt_d [GPR_NUM];
  logic             sb_err_q;
  logic             sb_err_d;
  logic [NUM_SRC-1:0] port_haz;
  logic             sat;

  // Pending-writer bookkeeping: issue adds, retire removes, simultaneous pair cancels
  always_comb begin
    sb_err_d = sb_err_q;
    cnt_d[0] = '0;
    for (int r = 1; r < GPR_NUM; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_fire && cur_we && (cur_dest == gpr_addr_t'(r))) begin
        if (!(ret_valid && (ret_dest == gpr_addr_t'(r))) && (cnt_q[r] != CNT_MAX)) begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end
      end else if (ret_valid && (ret_dest == gpr_addr_t'(r))) begin
        if (cnt_q[r] == '0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  // Scoreboard state, cleared immediately by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < GPR_NUM; r++) begin
        cnt_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

  genvar k;
  generate
    for (k = 0; k < NUM_SRC; k++) begin : g_src
      gpr_addr_t addr_k;
      logic      pend_k;

      assign addr_k = src_addr[k*GPR_ADDR_W +: GPR_ADDR_W];
      assign pend_k = (cnt_q[addr_k] != '0);

      hazard_fwd_mux #(
        .NUM_FWD (NUM_FWD),
        .DATA_W  (DATA_W)
      ) u_fwd_mux (
        .src_en      (src_en[k]),
        .src_addr    (addr_k),
        .rf_rdata    (rf_rdata[k*DATA_W +: DATA_W]),
        .fwd_valid   (fwd_valid),
        .fwd_dest    (fwd_dest),
        .fwd_data_ok (fwd_data_ok),
        .fwd_data    (fwd_data),
        .pend        (pend_k),
        .src_data    (src_data[k*DATA_W +: DATA_W]),
        .hazard      (port_haz[k])
      );
    end
  endgenerate

  // A writer at the pending limit may only issue if one retires in the same cycle
  always_comb begin
    sat = cur_we && (cur_dest != '0) && (cnt_q[cur_dest] == CNT_MAX) &&
          !(ret_valid && (ret_dest == cur_dest));
  end

  assign ds_stall = (|port_haz) | sat;

`ifdef ID_HAZ_STATS_EN
  logic [31:0] stall_cycles_q;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles_q <= '0;
    end else if (ds_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// tb/tb_id_hazard_unit.sv - self-checking bench for id_hazard_unit with a scoreboard model
module tb_id_hazard_unit;

  localparam int NS = 2;
  localparam int NF = 3;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NS-1:0]     src_en;
  logic [NS*5-1:0]   src_addr;
  logic [NS*DW-1:0]  rf_rdata;
  logic [NF-1:0]     fwd_valid;
  logic [NF*5-1:0]   fwd_dest;
  logic [NF-1:0]     fwd_data_ok;
  logic [NF*DW-1:0]  fwd_data;
  logic              cur_we;
  logic [4:0]        cur_dest;
  logic              issue_fire;
  logic              ret_valid;
  logic [4:0]        ret_dest;
  logic [NS*DW-1:0]  src_data;
  logic              ds_stall;
  logic              sb_err;
`ifdef ID_HAZ_STATS_EN
  logic [31:0]       stall_cycles;
`endif

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  int cnt_m [32];
  bit err_m;
`ifdef ID_HAZ_STATS_EN
  longint stall_m;
`endif

  always #5 clk = ~clk;

  id_hazard_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .src_en      (src_en),
    .src_addr    (src_addr),
    .rf_rdata    (rf_rdata),
    .fwd_valid   (fwd_valid),
    .fwd_dest    (fwd_dest),
    .fwd_data_ok (fwd_data_ok),
    .fwd_data    (fwd_data),
    .cur_we      (cur_we),
    .cur_dest    (cur_dest),
    .issue_fire  (issue_fire),
    .ret_valid   (ret_valid),
    .ret_dest    (ret_dest),
    .src_data    (src_data),
    .ds_stall    (ds_stall),
    .sb_err      (sb_err)
`ifdef ID_HAZ_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Model: hazard of one read port from the rules on addresses, channels and pending counts
  function automatic bit m_port_haz(int k);
    logic [4:0] a;
    a = src_addr[k*5 +: 5];
    if (!src_en[k] || a == 5'd0) return 1'b0;
    for (int i = 0; i < NF; i++)
      if (fwd_valid[i] && fwd_dest[i*5 +: 5] == a) return !fwd_data_ok[i];
    return cnt_m[a] != 0;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = cur_we && cur_dest != 5'd0 && cnt_m[cur_dest] == 3 && !(ret_valid && ret_dest == cur_dest);
    for (int k = 0; k < NS; k++) s = s | m_port_haz(k);
    return s;
  endfunction

  // Returns 1 when the operand value is defined, with that value in d
  function automatic bit m_data(input int k, output logic [31:0] d);
    logic [4:0] a;
    a = src_addr[k*5 +: 5];
    d = '0;
    if (a == 5'd0) return 1'b1;
    for (int i = 0; i < NF; i++)
      if (fwd_valid[i] && fwd_dest[i*5 +: 5] == a) begin
        d = fwd_data[i*DW +: DW];
        return fwd_data_ok[i];
      end
    d = rf_rdata[k*DW +: DW];
    return cnt_m[a] == 0;
  endfunction

  // Model state: pending writes per register and the sticky error
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) cnt_m[r] <= 0;
      err_m <= 1'b0;
    end else begin
      int inc_r;
      int dec_r;
      inc_r = (issue_fire && cur_we) ? int'(cur_dest) : 0;
      dec_r = ret_valid ? int'(ret_dest) : 0;
      if (!(inc_r != 0 && inc_r == dec_r)) begin
        if (inc_r != 0) cnt_m[inc_r] <= cnt_m[inc_r] + 1;
        if (dec_r != 0) begin
          if (cnt_m[dec_r] == 0) err_m <= 1'b1;
          else cnt_m[dec_r] <= cnt_m[dec_r] - 1;
        end
      end
    end
  end

`ifdef ID_HAZ_STATS_EN
  always @(posedge clk or negedge resetn) begin
    if (!resetn) stall_m <= 0;
    else if (m_stall() && stall_m < 64'hFFFF_FFFF) stall_m <= stall_m + 1;
  end
`endif

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] d;
      chk("ds_stall", {31'd0, ds_stall}, {31'd0, m_stall()});
      chk("sb_err", {31'd0, sb_err}, {31'd0, err_m});
      for (int k = 0; k < NS; k++)
        if (m_data(k, d)) chk($sformatf("src_data%0d", k), src_data[k*DW +: DW], d);
`ifdef ID_HAZ_STATS_EN
      chk("stall_cycles", stall_cycles, stall_m[31:0]);
`endif
    end
  end

  task automatic idle();
    src_en      = '0;
    src_addr    = '0;
    rf_rdata    = {32'h2222_0002, 32'h1111_0001};
    fwd_valid   = '0;
    fwd_dest    = '0;
    fwd_data_ok = '0;
    fwd_data    = '0;
    cur_we      = 1'b0;
    cur_dest    = '0;
    issue_fire  = 1'b0;
    ret_valid   = 1'b0;
    ret_dest    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] dst);
    step(); idle();
    issue_fire = 1'b1; cur_we = 1'b1; cur_dest = dst;
  endtask

  task automatic retire(input logic [4:0] dst);
    step(); idle();
    ret_valid = 1'b1; ret_dest = dst;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    cmp_en = 1'b1;
    repeat (2) step();
    src_en = 2'b01; src_addr = 10'd1;
    #1;
    chk("reset_stall", {31'd0, ds_stall}, 32'd0);
    chk("reset_err", {31'd0, sb_err}, 32'd0);
    chk("reset_data", src_data[31:0], 32'h1111_0001);
    step(); resetn = 1'b1;

    // Reset mid-cycle clears pending counts
    issue(5'd4);
    issue(5'd4);
    step(); idle();
    src_en = 2'b01; src_addr = 10'd4;
    #1;
    chk("cnt4_pending_stall", {31'd0, ds_stall}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_reset_stall", {31'd0, ds_stall}, 32'd0);
    step(); resetn = 1'b1;

    // Priority forwarding
    step(); idle();
    src_en = 2'b01; src_addr = 10'd5;
    fwd_valid = 3'b011; fwd_data_ok = 3'b011;
    fwd_dest = {5'd0, 5'd5, 5'd5};
    fwd_data = {32'd0, 32'hBEEF, 32'h1234};
    #1;
    chk("prio_data", src_data[31:0], 32'h1234);
    chk("prio_stall", {31'd0, ds_stall}, 32'd0);
    step(); fwd_valid = 3'b010;
    #1;
    chk("ch1_data", src_data[31:0], 32'hBEEF);
    step(); fwd_valid = 3'b011; fwd_data_ok = 3'b010;
    #1;
    chk("ch0_unready_stall", {31'd0, ds_stall}, 32'd1);

    // Load-use on port 1
    step(); idle();
    fwd_valid = 3'b001; fwd_dest = 15'd7; fwd_data_ok = 3'b000;
    src_en = 2'b10; src_addr = {5'd7, 5'd0};
    #1;
    chk("loaduse_stall", {31'd0, ds_stall}, 32'd1);
    step(); src_en = 2'b00;
    #1;
    chk("loaduse_noen", {31'd0, ds_stall}, 32'd0);

    // Divider: pending writer with no forwarding channel
    issue(5'd9);
    for (int c = 0; c < 3; c++) begin
      step(); idle(); src_en = 2'b01; src_addr = 10'd9;
      #1;
      chk("div_stall", {31'd0, ds_stall}, 32'd1);
    end
    step(); ret_valid = 1'b1; ret_dest = 5'd9;
    #1;
    chk("div_ret_cycle", {31'd0, ds_stall}, 32'd1);
    step(); idle(); src_en = 2'b01; src_addr = 10'd9;
    #1;
    chk("div_after_ret", {31'd0, ds_stall}, 32'd0);

    // Saturation of r3
    issue(5'd3);
    issue(5'd3);
    issue(5'd3);
    step(); idle(); cur_we = 1'b1; cur_dest = 5'd3;
    #1;
    chk("sat_stall", {31'd0, ds_stall}, 32'd1);
    ret_valid = 1'b1; ret_dest = 5'd3; issue_fire = 1'b1;
    #1;
    chk("sat_ret_stall", {31'd0, ds_stall}, 32'd0);
    step(); idle(); cur_we = 1'b1; cur_dest = 5'd3;
    #1;
    chk("sat_kept_at_3", {31'd0, ds_stall}, 32'd1);
    retire(5'd3);
    retire(5'd3);
    retire(5'd3);
    step(); idle(); src_en = 2'b01; src_addr = 10'd3;
    #1;
    chk("sat_drained", {31'd0, ds_stall}, 32'd0);

    // Constrained random traffic checked against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      step(); idle();
      src_en      = 2'($urandom);
      src_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf_rdata    = {$urandom, $urandom};
      fwd_valid   = 3'($urandom);
      fwd_dest    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data_ok = 3'($urandom);
      fwd_data    = {$urandom, $urandom, $urandom};
      cur_we      = 1'($urandom);
      cur_dest    = 5'($urandom_range(0, 7));
      r = $urandom_range(1, 7);
      if (cnt_m[r] > 0 && $urandom_range(0, 1) == 1) begin
        ret_valid = 1'b1; ret_dest = 5'(r);
      end
      issue_fire = ($urandom_range(0, 1) == 1) && !m_stall();
    end

    // r0 reads as zero, retire on empty counter is sticky error
    step(); idle(); resetn = 1'b0;
    step(); resetn = 1'b1;
    step(); idle();
    src_en = 2'b01; src_addr = 10'd0;
    fwd_valid = 3'b001; fwd_dest = 15'd0; fwd_data_ok = 3'b001; fwd_data = {64'd0, 32'hFFFF};
    #1;
    chk("r0_data", src_data[31:0], 32'd0);
    chk("r0_stall", {31'd0, ds_stall}, 32'd0);
    retire(5'd6);
    #1;
    chk("err_before_edge", {31'd0, sb_err}, 32'd0);
    step(); idle();
    #1;
    chk("err_set", {31'd0, sb_err}, 32'd1);
    repeat (3) step();
    chk("err_sticky", {31'd0, sb_err}, 32'd1);

    step();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
